// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: edge-mode encoding used to
// build per-channel interrupt masks, and a constant-foldable clog2.
package input_conditioner_pkg;

    // Which debounced edges of a channel set its pending bit.
    // Bit 0 selects the rising edge, bit 1 the falling edge.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Combine one bit of each mask into the channel's edge mode.
    function automatic edge_mode_e channel_mode(input logic rise_sel, input logic fall_sel);
        return edge_mode_e'({fall_sel, rise_sel});
    endfunction

    function automatic logic mode_has_rise(input edge_mode_e mode);
        return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    endfunction

    function automatic logic mode_has_fall(input edge_mode_e mode);
        return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// Single conditioner channel: polarity fix, synchroniser chain, counter
// debouncer and registered one-cycle rise/fall pulses.
module input_conditioner_ch
    import input_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        INVERT          = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned          CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                   pol;
    logic                   synced;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Polarity is fixed ahead of the first flop so an idle active-low pin
    // enters the chain as 0 and never produces a spurious edge after reset.
    assign pol    = din ^ INVERT;
    assign synced = sync_q[SYNC_STAGES-1];

    // Plain shift chain, nothing between stages.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pol};
    end

    // Debounce: count consecutive cycles the synced value differs from the
    // accepted level; accept on the last count and emit the matching pulse.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = synced;
            rise_d  = synced;
            fall_d  = ~synced;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Channel state with asynchronous clear, so a mid-debounce reset
    // drops the count and level immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: per-channel debounced levels and edge
// pulses, sticky interrupt-pending bits and a combined interrupt request.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] ACTIVE_LOW_MASK = '0,
    parameter logic [WIDTH-1:0] RISE_MASK       = '1,
    parameter logic [WIDTH-1:0] FALL_MASK       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] irq_en,
    input  logic [WIDTH-1:0] pend_clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] pend,
    output logic             irq
);

    logic [WIDTH-1:0] pend_set;
    logic [WIDTH-1:0] pend_q, pend_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        localparam edge_mode_e MODE = channel_mode(RISE_MASK[i], FALL_MASK[i]);

        input_conditioner_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (ACTIVE_LOW_MASK[i])
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .din   (din[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );

        assign pend_set[i] = (rise[i] & mode_has_rise(MODE))
                           | (fall[i] & mode_has_fall(MODE));
    end

    // Set has priority over a same-cycle clear so no event is dropped.
    always_comb begin
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    // Sticky pending bits, recorded regardless of irq_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;
    assign irq  = |(pend_q & irq_en);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: expectations are queued with the
// cycle they fall due and compared on the falling clock edge.
module tb_input_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] din;
    logic [3:0] irq_en;
    logic [3:0] pend_clr;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] pend;
    logic       irq;

    int cyc_cnt;
    int checks;
    int errors;

    int          q_cyc[$];
    string       q_tag[$];
    logic [16:0] q_exp[$];

    input_conditioner #(
        .WIDTH           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .ACTIVE_LOW_MASK (4'b1000),
        .RISE_MASK       (4'b0011),
        .FALL_MASK       (4'b0110)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .irq_en   (irq_en),
        .pend_clr (pend_clr),
        .level    (level),
        .rise     (rise),
        .fall     (fall),
        .pend     (pend),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Queue an expected output snapshot dc cycles from now.
    task automatic expect_at(input int dc, input string tag, input logic [3:0] l,
                             input logic [3:0] r, input logic [3:0] f,
                             input logic [3:0] p, input logic q);
        q_cyc.push_back(cyc_cnt + dc);
        q_tag.push_back(tag);
        q_exp.push_back({l, r, f, p, q});
    endtask

    // Compare every queued expectation that is due this cycle.
    task automatic drain();
        logic [16:0] obs;
        logic [16:0] e;
        int          c;
        string       t;
        obs = {level, rise, fall, pend, irq};
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc_cnt) begin
            c = q_cyc.pop_front();
            t = q_tag.pop_front();
            e = q_exp.pop_front();
            checks++;
            assert (c == cyc_cnt && obs === e) else begin
                errors++;
                $error("FAIL %s cyc=%0d due=%0d observed lvl/rise/fall/pend/irq=%b/%b/%b/%b/%b expected %b/%b/%b/%b/%b",
                       t, cyc_cnt, c, obs[16:13], obs[12:9], obs[8:5], obs[4:1], obs[0],
                       e[16:13], e[12:9], e[8:5], e[4:1], e[0]);
            end
        end
    endtask

    // Check on the falling edge, then advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(negedge clk);
        drain();
        @(posedge clk);
        cyc_cnt++;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        cyc_cnt  = 0;
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        din      = 4'b1000;
        irq_en   = 4'hF;
        pend_clr = 4'b0000;
        @(posedge clk);
        cyc_cnt = 1;
        #1;

        // 1: reset held with idle active-low button, then released
        for (int d = 0; d < 20; d++) expect_at(d, "reset_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        run(20);
        reset = 1'b0;
        for (int d = 0; d < 16; d++) expect_at(d, "reset_release", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        run(16);

        // 2: clean step on channel 0
        din = 4'b1001;
        expect_at(9,  "ch0_rise_early", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        expect_at(10, "ch0_rise_level", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        expect_at(11, "ch0_rise_pend",  4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        run(12);

        // 3: channel 1 bouncing with 5-cycle pulses never gets accepted
        for (int k = 0; k < 100; k++) begin
            if (k % 5 == 0) din[1] = ~din[1];
            expect_at(0, "ch1_bounce", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
            tick();
        end
        din = 4'b1011;
        expect_at(9,  "ch1_stable_early", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        expect_at(10, "ch1_stable_level", 4'b0011, 4'b0010, 4'b0000, 4'b0001, 1'b1);
        expect_at(11, "ch1_stable_pend",  4'b0011, 4'b0000, 4'b0000, 4'b0011, 1'b1);
        run(12);

        // 4: channel 0 falls (not in fall mask), then rises with a same-cycle clear
        din = 4'b1010;
        expect_at(9,  "ch0_fall_early", 4'b0011, 4'b0000, 4'b0000, 4'b0011, 1'b1);
        expect_at(10, "ch0_fall_pulse", 4'b0010, 4'b0000, 4'b0001, 4'b0011, 1'b1);
        expect_at(11, "ch0_fall_after", 4'b0010, 4'b0000, 4'b0000, 4'b0011, 1'b1);
        run(12);
        din = 4'b1011;
        expect_at(9, "ch0_rise2_early", 4'b0010, 4'b0000, 4'b0000, 4'b0011, 1'b1);
        run(10);
        expect_at(0, "ch0_rise2_pulse", 4'b0011, 4'b0001, 4'b0000, 4'b0011, 1'b1);
        pend_clr = 4'b0001;
        expect_at(1, "set_beats_clear", 4'b0011, 4'b0000, 4'b0000, 4'b0011, 1'b1);
        tick();
        pend_clr = 4'b0000;
        run(2);
        pend_clr = 4'b0011;
        expect_at(1, "idle_clear", 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        pend_clr = 4'b0000;
        expect_at(3, "clear_holds", 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        run(4);

        // 5: channel 2 rise (masked off) then fall (sets pend)
        din = 4'b1111;
        expect_at(10, "ch2_rise_pulse", 4'b0111, 4'b0100, 4'b0000, 4'b0000, 1'b0);
        expect_at(11, "ch2_rise_nopend", 4'b0111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        run(12);
        din = 4'b1011;
        expect_at(10, "ch2_fall_pulse", 4'b0011, 4'b0000, 4'b0100, 4'b0000, 1'b0);
        expect_at(11, "ch2_fall_pend",  4'b0011, 4'b0000, 4'b0000, 4'b0100, 1'b1);
        run(12);

        // 5b: active-low channel 3 press and release, never pending
        din = 4'b0011;
        expect_at(10, "ch3_press_pulse", 4'b1011, 4'b1000, 4'b0000, 4'b0100, 1'b1);
        expect_at(11, "ch3_press_after", 4'b1011, 4'b0000, 4'b0000, 4'b0100, 1'b1);
        run(12);
        din = 4'b1011;
        expect_at(10, "ch3_release_pulse", 4'b0011, 4'b0000, 4'b1000, 4'b0100, 1'b1);
        expect_at(11, "ch3_release_after", 4'b0011, 4'b0000, 4'b0000, 4'b0100, 1'b1);
        run(12);

        // simultaneous falls on 0 and 1 with irq disabled, then enable
        pend_clr = 4'b0100;
        expect_at(1, "clear_ch2", 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        pend_clr = 4'b0000;
        irq_en   = 4'b0000;
        din      = 4'b1000;
        expect_at(9,  "dual_fall_early", 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        expect_at(10, "dual_fall_pulse", 4'b0000, 4'b0000, 4'b0011, 4'b0000, 1'b0);
        expect_at(11, "pend_irq_masked", 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0);
        run(12);
        irq_en = 4'hF;
        expect_at(0, "irq_enable_late", 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1);
        tick();

        // 6: asynchronous reset with channel 0 count at 5
        din = 4'b1001;
        run(7);
        for (int d = 0; d < 4; d++) expect_at(d, "async_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        #2;
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        for (int d = 1; d < 10; d++) expect_at(d, "post_reset_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        expect_at(10, "post_reset_level", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        expect_at(11, "post_reset_pend",  4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        run(12);

        run(2);
        checks++;
        assert (q_cyc.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drained observed %0d pending expected 0", q_cyc.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
